// File: rtl/regex_pc_scheduler_pkg.sv
// Shared types and default sizes for the regex thread-token scheduler.
// Holds the default-width token struct and the default FIFO depth.
package regex_sched_package;

   localparam int PC_WIDTH_DEF        = 9;
   localparam int CC_ID_BITS_DEF      = 2;
   localparam int NUM_CPUS_DEF        = 4;
   localparam int FIFO_DEPTH_POW2_DEF = 2;
   localparam int FIFO_DEPTH_DEF      = 2 ** FIFO_DEPTH_POW2_DEF;

   typedef struct packed {
      logic [PC_WIDTH_DEF-1:0]   pc;
      logic [CC_ID_BITS_DEF-1:0] cc_id;
   } pc_token_t;

endpackage

// File: rtl/regex_pc_scheduler_if.sv
// Token, dispatch, retire and status signals of the regex thread-token scheduler.
// The dedup_drop signal exists only when REGEX_PC_SCHED_DEDUP_EN is defined.
interface regex_pc_scheduler_if import regex_sched_package::*; #(
   parameter int PC_WIDTH        = PC_WIDTH_DEF,
   parameter int CC_ID_BITS      = CC_ID_BITS_DEF,
   parameter int NUM_CPUS        = NUM_CPUS_DEF,
   parameter int FIFO_DEPTH_POW2 = FIFO_DEPTH_POW2_DEF
);

   logic                           in_valid;
   logic [PC_WIDTH-1:0]            in_pc;
   logic [CC_ID_BITS-1:0]          in_cc_id;
   logic                           in_ready;
   logic [NUM_CPUS-1:0]            out_valid;
   logic [PC_WIDTH-1:0]            out_pc;
   logic [CC_ID_BITS-1:0]          out_cc_id;
   logic [NUM_CPUS-1:0]            out_ready;
   logic [NUM_CPUS-1:0]            retire_valid;
   logic [NUM_CPUS*CC_ID_BITS-1:0] retire_cc_id;
   logic [2**CC_ID_BITS-1:0]       cc_idle;
   logic [FIFO_DEPTH_POW2:0]       fifo_count;
   logic                           error;
`ifdef REGEX_PC_SCHED_DEDUP_EN
   logic                           dedup_drop;
`endif

   modport master (
      output in_valid, in_pc, in_cc_id, out_ready, retire_valid, retire_cc_id,
      input  in_ready, out_valid, out_pc, out_cc_id, cc_idle, fifo_count, error
`ifdef REGEX_PC_SCHED_DEDUP_EN
      , input dedup_drop
`endif
   );

   modport slave (
      input  in_valid, in_pc, in_cc_id, out_ready, retire_valid, retire_cc_id,
      output in_ready, out_valid, out_pc, out_cc_id, cc_idle, fifo_count, error
`ifdef REGEX_PC_SCHED_DEDUP_EN
      , output dedup_drop
`endif
   );

endinterface

// File: rtl/regex_pc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr
// (modulo NUM_CPUS) and returns its one-hot grant and the pointer that follows it.
module regex_rr_arbiter import regex_sched_package::*; #(
   parameter int NUM_CPUS = NUM_CPUS_DEF,
   parameter int PTR_W    = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1
) (
   input  logic [NUM_CPUS-1:0] req,
   input  logic [PTR_W-1:0]    ptr,
   output logic [NUM_CPUS-1:0] grant,
   output logic [PTR_W-1:0]    next_ptr
);

   int idx;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      idx      = 0;
      // Walk from the farthest offset back to ptr so the nearest requester is the one that sticks.
      for (int off = NUM_CPUS - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % NUM_CPUS;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            next_ptr   = PTR_W'((idx + 1) % NUM_CPUS);
         end
      end
   end

endmodule

// File: rtl/regex_pc_scheduler.sv
// Thread-token scheduler: buffers (pc, cc_id) tokens, dispatches them round-robin to
// ready CPUs and tracks in-flight threads per context. Optional: REGEX_PC_SCHED_DEDUP_EN.
module regex_pc_scheduler import regex_sched_package::*; #(
   parameter int PC_WIDTH        = PC_WIDTH_DEF,
   parameter int CC_ID_BITS      = CC_ID_BITS_DEF,
   parameter int NUM_CPUS        = NUM_CPUS_DEF,
   parameter int FIFO_DEPTH_POW2 = FIFO_DEPTH_POW2_DEF,
   parameter int CNT_WIDTH       = FIFO_DEPTH_POW2 + $clog2(NUM_CPUS) + 2
) (
   input logic                 clk,
   input logic                 rst,
   regex_pc_scheduler_if.slave bus
);

   localparam int DEPTH   = 2 ** FIFO_DEPTH_POW2;
   localparam int NUM_CC  = 2 ** CC_ID_BITS;
   localparam int PTR_W   = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
   localparam int CNT_MAX = 2 ** CNT_WIDTH - 1;

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [CC_ID_BITS-1:0] cc_id;
   } token_t;

   token_t                   mem [DEPTH];
   token_t                   in_tok;
   token_t                   head;
   logic [FIFO_DEPTH_POW2:0] wr_ptr;
   logic [FIFO_DEPTH_POW2:0] rd_ptr;
   logic [FIFO_DEPTH_POW2:0] count;
   logic                     full;
   logic                     empty;
   logic                     accept;
   logic                     dup;
   logic                     push;
   logic                     pop;
   logic [NUM_CPUS-1:0]      grant;
   logic [PTR_W-1:0]         rr_ptr;
   logic [PTR_W-1:0]         rr_next;
   logic [CNT_WIDTH-1:0]     cnt      [NUM_CC];
   logic [CNT_WIDTH-1:0]     cnt_next [NUM_CC];
   logic [NUM_CC-1:0]        bad;
   logic [NUM_CC-1:0]        idle_q;
   logic                     error_q;
   int                       sum;

   assign count  = wr_ptr - rd_ptr;
   assign full   = (count == (FIFO_DEPTH_POW2 + 1)'(DEPTH));
   assign empty  = (wr_ptr == rd_ptr);
   assign in_tok = {bus.in_pc, bus.in_cc_id};
   assign head   = mem[rd_ptr[FIFO_DEPTH_POW2-1:0]];
   assign accept = bus.in_valid && !full;
   assign push   = accept && !dup;
   assign pop    = |grant;

`ifdef REGEX_PC_SCHED_DEDUP_EN
   logic [FIFO_DEPTH_POW2-1:0] slot;

   // The head is an occupied slot, so a token matching the head being dispatched is also caught.
   always_comb begin
      dup  = 1'b0;
      slot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr[FIFO_DEPTH_POW2-1:0] + FIFO_DEPTH_POW2'(i);
         if (i < int'(count) && mem[slot] == in_tok) dup = 1'b1;
      end
   end

   assign bus.dedup_drop = accept && dup;
`else
   assign dup = 1'b0;
`endif

   regex_rr_arbiter #(
      .NUM_CPUS (NUM_CPUS),
      .PTR_W    (PTR_W)
   ) u_arb (
      .req      (bus.out_ready & {NUM_CPUS{!empty}}),
      .ptr      (rr_ptr),
      .grant    (grant),
      .next_ptr (rr_next)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         rr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rr_ptr <= rr_next;
         end
      end
   end

   // NOTE: token storage is not reset; pointers define validity and the outputs are gated while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_DEPTH_POW2-1:0]] <= in_tok;
   end

   // Net change per context: the push adds one, each matching retire removes one; clamp both ways.
   always_comb begin
      sum = 0;
      bad = '0;
      for (int c = 0; c < NUM_CC; c++) begin
         sum = int'(cnt[c]) + ((push && int'(bus.in_cc_id) == c) ? 1 : 0);
         for (int i = 0; i < NUM_CPUS; i++) begin
            if (bus.retire_valid[i] && int'(bus.retire_cc_id[i*CC_ID_BITS +: CC_ID_BITS]) == c)
               sum = sum - 1;
         end
         if (sum < 0) begin
            cnt_next[c] = '0;
            bad[c]      = 1'b1;
         end else if (sum > CNT_MAX) begin
            cnt_next[c] = CNT_WIDTH'(CNT_MAX);
            bad[c]      = 1'b1;
         end else begin
            cnt_next[c] = CNT_WIDTH'(sum);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CC; c++) cnt[c] <= '0;
         idle_q  <= '1;
         error_q <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CC; c++) begin
            cnt[c]    <= cnt_next[c];
            idle_q[c] <= (cnt_next[c] == '0);
         end
         error_q <= error_q | (|bad);
      end
   end

   assign bus.in_ready   = !full;
   assign bus.out_valid  = grant;
   assign bus.out_pc     = empty ? '0 : head.pc;
   assign bus.out_cc_id  = empty ? '0 : head.cc_id;
   assign bus.cc_idle    = idle_q;
   assign bus.fifo_count = count;
   assign bus.error      = error_q;

endmodule

// File: tb/tb_regex_pc_scheduler.sv
// Scoreboard bench for regex_pc_scheduler: expected tokens are queued when pushed and
// compared when dispatched; counters are observed through cc_idle and error.
module tb_regex_pc_scheduler;
   import regex_sched_package::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   tb_rr;
   pc_token_t exp_q[$];

   regex_pc_scheduler_if bus ();

   regex_pc_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      tb_rr = 0;
      tick();
   endtask

   function automatic int model_grant_idx(input logic [3:0] ready, input int rr);
      for (int off = 0; off < 4; off++) begin
         if (ready[(rr + off) % 4]) return (rr + off) % 4;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      bus.in_valid = 1'b1; bus.in_pc = 9'd7; bus.in_cc_id = 2'd0;
      bus.out_ready = 4'hf; bus.retire_valid = 4'h0; bus.retire_cc_id = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0000", bus.out_valid); end
      checks++; if (bus.cc_idle !== 4'hf) begin errors++; $display("FAIL reset_cc_idle: got %b expected 1111", bus.cc_idle); end
      checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", bus.fifo_count); end
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.error); end
      checks++; if (bus.out_pc !== 9'd0 || bus.out_cc_id !== 2'd0) begin errors++; $display("FAIL reset_out_token: got pc=%0d cc=%0d expected 0/0", bus.out_pc, bus.out_cc_id); end
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tb_rr = 0;
      tick(); tick();
      checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL post_reset_idle_count: got %0d expected 0", bus.fifo_count); end
   endtask

   task automatic test_fill();
      bus.out_ready = 4'h0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1; bus.in_pc = 9'(245 + k); bus.in_cc_id = 2'd1;
         #1;
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", k, bus.in_ready); end
         checks++; if (bus.out_valid !== 4'h0) begin errors++; $display("FAIL fill_out_valid[%0d]: got %b expected 0000", k, bus.out_valid); end
         exp_q.push_back('{pc: 9'(245 + k), cc_id: 2'd1});
         tick();
      end
      bus.in_pc = 9'd249;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", bus.fifo_count); end
      checks++; if (bus.cc_idle !== 4'b1101) begin errors++; $display("FAIL full_cc_idle: got %b expected 1101", bus.cc_idle); end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL refused_push_count: got %0d expected 4", bus.fifo_count); end
   endtask

   task automatic test_round_robin();
      pc_token_t tok;
      bus.out_ready = 4'hf;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.out_valid !== 4'(1 << k)) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.out_valid, 4'(1 << k)); end
         if (|bus.out_valid && exp_q.size() > 0) begin
            tok = exp_q.pop_front();
            checks++; if (bus.out_pc !== tok.pc || bus.out_cc_id !== tok.cc_id) begin errors++; $display("FAIL rr_token[%0d]: got pc=%0d cc=%0d expected pc=%0d cc=%0d", k, bus.out_pc, bus.out_cc_id, tok.pc, tok.cc_id); end
         end
         tick();
      end
      tb_rr = 0;
      checks++; if (bus.fifo_count !== 3'd0 || bus.out_valid !== 4'h0) begin errors++; $display("FAIL rr_drained: got count=%0d valid=%b expected 0/0000", bus.fifo_count, bus.out_valid); end
      bus.retire_valid = 4'hf; bus.retire_cc_id = {4{2'd1}};
      tick();
      bus.retire_valid = 4'h0;
      checks++; if (bus.cc_idle !== 4'hf || bus.error !== 1'b0) begin errors++; $display("FAIL rr_retire_all: got idle=%b err=%b expected 1111/0", bus.cc_idle, bus.error); end
   endtask

   task automatic test_retire_accounting();
      pc_token_t tok;
      int        gi;
      bus.out_ready = 4'h0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1; bus.in_pc = 9'(10 + k); bus.in_cc_id = 2'd2;
         exp_q.push_back('{pc: 9'(10 + k), cc_id: 2'd2});
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 4'hf;
      for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
         #1;
         gi = model_grant_idx(bus.out_ready, tb_rr);
         checks++; if (bus.out_valid !== 4'(1 << gi)) begin errors++; $display("FAIL ra_grant[%0d]: got %b expected %b", cyc, bus.out_valid, 4'(1 << gi)); end
         if (|bus.out_valid) begin
            tok = exp_q.pop_front();
            tb_rr = (gi + 1) % 4;
            checks++; if (bus.out_pc !== tok.pc) begin errors++; $display("FAIL ra_pc[%0d]: got %0d expected %0d", cyc, bus.out_pc, tok.pc); end
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ra_drain_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
      bus.out_ready = 4'h0;
      bus.retire_valid = 4'b0011; bus.retire_cc_id = {2'd0, 2'd0, 2'd2, 2'd2};
      tick();
      checks++; if (bus.cc_idle !== 4'b1011) begin errors++; $display("FAIL ra_double_retire: got %b expected 1011", bus.cc_idle); end
      bus.retire_valid = 4'b0001;
      tick();
      bus.retire_valid = 4'h0;
      checks++; if (bus.cc_idle !== 4'hf || bus.error !== 1'b0) begin errors++; $display("FAIL ra_last_retire: got idle=%b err=%b expected 1111/0", bus.cc_idle, bus.error); end
   endtask

   task automatic test_push_retire();
      bus.out_ready = 4'h0;
      bus.in_valid = 1'b1; bus.in_pc = 9'd20; bus.in_cc_id = 2'd3;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.cc_idle !== 4'b0111) begin errors++; $display("FAIL pr_setup: got %b expected 0111", bus.cc_idle); end
      bus.in_valid = 1'b1; bus.in_pc = 9'd21; bus.in_cc_id = 2'd3;
      bus.retire_valid = 4'b0001; bus.retire_cc_id = {2'd0, 2'd0, 2'd0, 2'd3};
      tick();
      bus.in_valid = 1'b0; bus.retire_valid = 4'h0;
      checks++; if (bus.cc_idle[3] !== 1'b0 || bus.error !== 1'b0 || bus.fifo_count !== 3'd2) begin errors++; $display("FAIL pr_net: got idle3=%b err=%b count=%0d expected 0/0/2", bus.cc_idle[3], bus.error, bus.fifo_count); end
      bus.retire_valid = 4'b0001;
      tick();
      checks++; if (bus.cc_idle !== 4'hf || bus.error !== 1'b0) begin errors++; $display("FAIL pr_to_zero: got idle=%b err=%b expected 1111/0", bus.cc_idle, bus.error); end
      tick();
      bus.retire_valid = 4'h0;
      checks++; if (bus.error !== 1'b1 || bus.cc_idle !== 4'hf) begin errors++; $display("FAIL pr_underflow: got err=%b idle=%b expected 1/1111", bus.error, bus.cc_idle); end
      tick();
      checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL pr_sticky: got %b expected 1", bus.error); end
      // Asynchronous reset away from any clock edge, with tokens still stored.
      bus.out_ready = 4'hf;
      #2;
      rst = 1'b0;
      #1;
      checks++; if (bus.fifo_count !== 3'd0 || bus.error !== 1'b0 || bus.cc_idle !== 4'hf || bus.out_valid !== 4'h0) begin errors++; $display("FAIL async_reset: got count=%0d err=%b idle=%b valid=%b expected 0/0/1111/0000", bus.fifo_count, bus.error, bus.cc_idle, bus.out_valid); end
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      tb_rr = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      pc_token_t tok;
      int        gi;
      logic      exp_ready;
      bus.out_ready = 4'b0101;
      for (int k = 0; k < 40; k++) begin
         if (k >= 12 && exp_q.size() == 0) break;
         bus.in_valid = (k < 12); bus.in_pc = 9'(100 + k); bus.in_cc_id = 2'(k % 4);
         #1;
         exp_ready = (exp_q.size() < 4);
         gi = (exp_q.size() > 0) ? model_grant_idx(bus.out_ready, tb_rr) : -1;
         checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected %b", k, bus.in_ready, exp_ready); end
         checks++; if (bus.out_valid !== ((gi < 0) ? 4'h0 : 4'(1 << gi))) begin errors++; $display("FAIL b2b_grant[%0d]: got %b expected idx %0d", k, bus.out_valid, gi); end
         if (gi >= 0) begin
            tok = exp_q.pop_front();
            tb_rr = (gi + 1) % 4;
            checks++; if (bus.out_pc !== tok.pc || bus.out_cc_id !== tok.cc_id) begin errors++; $display("FAIL b2b_token[%0d]: got pc=%0d cc=%0d expected pc=%0d cc=%0d", k, bus.out_pc, bus.out_cc_id, tok.pc, tok.cc_id); end
         end
         if (bus.in_valid && exp_ready) exp_q.push_back('{pc: 9'(100 + k), cc_id: 2'(k % 4)});
         tick();
      end
      bus.in_valid = 1'b0;
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
      checks++; if (bus.cc_idle !== 4'h0) begin errors++; $display("FAIL b2b_in_flight: got %b expected 0000", bus.cc_idle); end
      for (int c = 0; c < 4; c++) begin
         bus.retire_valid = 4'b0111; bus.retire_cc_id = {4{2'(c)}};
         tick();
         checks++; if (bus.cc_idle[c] !== 1'b1) begin errors++; $display("FAIL b2b_retire[%0d]: got %b expected 1", c, bus.cc_idle[c]); end
      end
      bus.retire_valid = 4'h0;
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL b2b_error: got %b expected 0", bus.error); end
   endtask

   task automatic test_saturate();
      bus.out_ready = 4'hf;
      for (int k = 0; k < 64; k++) begin
         bus.in_valid = 1'b1; bus.in_pc = 9'(k); bus.in_cc_id = 2'd0;
         #1;
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sat_in_ready[%0d]: got %b expected 1", k, bus.in_ready); end
         tick();
         if (k == 62) begin
            checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL sat_at_max: got %b expected 0", bus.error); end
         end
      end
      bus.in_valid = 1'b0;
      tick(); tick();
      checks++; if (bus.error !== 1'b1 || bus.cc_idle[0] !== 1'b0) begin errors++; $display("FAIL sat_overflow: got err=%b idle0=%b expected 1/0", bus.error, bus.cc_idle[0]); end
      do_reset();
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL sat_reset_clear: got %b expected 0", bus.error); end
   endtask

   task automatic test_dedup();
`ifdef REGEX_PC_SCHED_DEDUP_EN
      localparam int EXP_STORED = 1;
`else
      localparam int EXP_STORED = 2;
`endif
      bus.out_ready = 4'h0;
      bus.in_valid = 1'b1; bus.in_pc = 9'd250; bus.in_cc_id = 2'd0;
      #1;
`ifdef REGEX_PC_SCHED_DEDUP_EN
      checks++; if (bus.dedup_drop !== 1'b0) begin errors++; $display("FAIL dedup_first: got %b expected 0", bus.dedup_drop); end
`endif
      tick();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dedup_in_ready: got %b expected 1", bus.in_ready); end
`ifdef REGEX_PC_SCHED_DEDUP_EN
      checks++; if (bus.dedup_drop !== 1'b1) begin errors++; $display("FAIL dedup_pulse: got %b expected 1", bus.dedup_drop); end
`endif
      tick();
      bus.in_valid = 1'b0;
      #1;
`ifdef REGEX_PC_SCHED_DEDUP_EN
      checks++; if (bus.dedup_drop !== 1'b0) begin errors++; $display("FAIL dedup_pulse_end: got %b expected 0", bus.dedup_drop); end
`endif
      checks++; if (bus.fifo_count !== 3'(EXP_STORED)) begin errors++; $display("FAIL dedup_count: got %0d expected %0d", bus.fifo_count, EXP_STORED); end
      bus.out_ready = 4'hf;
      repeat (EXP_STORED) tick();
      bus.out_ready = 4'h0;
      checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL dedup_drain: got %0d expected 0", bus.fifo_count); end
      bus.retire_valid = 4'b0001; bus.retire_cc_id = 8'h00;
      repeat (EXP_STORED - 1) tick();
      #1;
      checks++; if (bus.cc_idle[0] !== 1'b0) begin errors++; $display("FAIL dedup_cnt_nonzero: got %b expected 0", bus.cc_idle[0]); end
      tick();
      bus.retire_valid = 4'h0;
      checks++; if (bus.cc_idle !== 4'hf || bus.error !== 1'b0) begin errors++; $display("FAIL dedup_cnt_one: got idle=%b err=%b expected 1111/0", bus.cc_idle, bus.error); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      tb_rr  = 0;
      test_reset();
      test_fill();
      test_round_robin();
      test_retire_accounting();
      test_push_retire();
      test_back_to_back();
      test_saturate();
      test_dedup();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regex_pc_scheduler.md
Name: regex_pc_scheduler

Overview:
- Parametrised thread-token scheduler that sits in front of a bank of NUM_CPUS regex_cpu_pipelined instances.
- Buffers (pc, cc_id) tokens from the input engine and the CPUs' feedback into one FIFO.
- Dispatches buffered tokens round-robin to whichever CPUs are ready.
- Tracks per-character-context in-flight thread counts, so the controller knows when a cc_id window has drained and may be recycled.

Parameters:
- PC_WIDTH, 9, width of a program counter.
- CC_ID_BITS, 2, width of character-context id; 2**CC_ID_BITS contexts.
- NUM_CPUS, 4, number of dispatch targets (power of 2, >=1).
- FIFO_DEPTH_POW2, 2, token FIFO depth = 2**FIFO_DEPTH_POW2.
- CNT_WIDTH, FIFO_DEPTH_POW2+$clog2(NUM_CPUS)+2, width of each per-context in-flight counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; release synchronised externally).
- in_valid  in  1  token offered.
- in_pc  in  PC_WIDTH  token pc.
- in_cc_id  in  CC_ID_BITS  token context id.
- in_ready  out  1  token accepted when in_valid&in_ready.
- out_valid  out  NUM_CPUS  one-hot: token offered to CPU i.
- out_pc  out  PC_WIDTH  head-token pc, shared by all CPUs.
- out_cc_id  out  CC_ID_BITS  head-token cc_id.
- out_ready  in  NUM_CPUS  CPU i can take a token.
- retire_valid  in  NUM_CPUS  CPU i finished one thread this cycle.
- retire_cc_id  in  NUM_CPUS*CC_ID_BITS  context of each retiring thread, CPU i at [i*CC_ID_BITS+:CC_ID_BITS].
- cc_idle  out  2**CC_ID_BITS  bit c=1 when context c has zero in-flight threads.
- fifo_count  out  FIFO_DEPTH_POW2+1  tokens currently stored.
- error  out  1  sticky counter underflow/overflow flag.

Behaviour:
- Reset values:
  - FIFO empty; fifo_count=0; in_ready=1.
  - out_valid=0; out_pc=0; out_cc_id=0.
  - all counters 0; cc_idle all 1; error=0.
  - round-robin pointer=0.
- FIFO:
  - Registered storage, wrap-around read/write pointers with one extra bit for full/empty.
  - in_ready = !full; no combinational dependency on out_ready.
  - Simultaneous push and pop when full is NOT allowed (in_ready is already 0).
  - Simultaneous push and pop when non-empty: count unchanged.
  - No bypass: a token accepted at edge t is dispatchable at earliest in the cycle after t, so minimum in->out latency is 1 cycle.
- Dispatch:
  - Each cycle, if FIFO non-empty, grant = first CPU i with out_ready[i]=1, searching from rr_ptr upward modulo NUM_CPUS.
  - out_valid = grant one-hot. out_ready may combinationally steer out_valid; this is an internal, documented deviation from valid-before-ready.
  - On a grant: pop the head; rr_ptr <= granted index+1 (mod NUM_CPUS).
  - No grant: rr_ptr holds.
  - At most one dispatch per cycle.
- In-flight counters, one per context c:
  - Each edge: cnt[c] += (push && in_cc_id==c) - popcount over i of (retire_valid[i] && retire_cc_id_i==c).
  - Pops do not change counts; a dispatched token stays in flight until retired.
  - cc_idle[c] = (cnt[c]==0), registered (reflects the counter after the edge).
  - A retire that would drive cnt below 0 clamps it at 0 and sets error.
  - An increment that would exceed 2**CNT_WIDTH-1 saturates and sets error.
  - error clears only on reset.
- Simultaneous events:
  - Push and retire on the same context in one cycle net out, so 1 push + 1 retire leaves the count unchanged.
  - Multiple CPUs may retire the same context in one cycle; all are counted.
- Reset mid-operation: all stored tokens are discarded and counters are zeroed immediately, independent of clk.

Optional Feature:
- Macro: REGEX_PC_SCHED_DEDUP_EN.
- Defined:
  - An offered token whose (pc, cc_id) equals any valid FIFO entry, or the head being dispatched this cycle, is accepted (in_ready per normal rule) but not stored.
  - Its counter is not incremented.
  - Output dedup_drop (1 bit, reset 0) pulses high for that cycle.
  - This removes redundant NFA threads.
- Not defined: every accepted token is stored; the dedup_drop port is absent.

Decomposition:
- Package regex_sched_package holds:
  - typedef struct packed {pc, cc_id} pc_token_t, parametrised via localparams matching the defaults;
  - a constant for the default FIFO depth.
- One sub-module is natural: regex_rr_arbiter (NUM_CPUS requests + pointer -> one-hot grant + next pointer), purely combinational with the pointer register in the parent.

Test Plan:
- Reset: rst=0 with in_valid=1 -> in_ready=1, out_valid=0, cc_idle=4'b1111, fifo_count=0; after release nothing is stored until the first clk edge with in_valid.
- Fill:
  - Stimulus: push pcs 245..248 with cc_id=1 while out_ready=0.
  - Response: fifo_count=4, in_ready=0, cc_idle=4'b1101. A fifth push is refused and the stored data is unchanged.
- Round robin:
  - Stimulus: out_ready=4'b1111 with 4 tokens queued.
  - Response: grants 0001,0010,0100,1000 on consecutive cycles; out_pc=245,246,247,248 in order; fifo_count reaches 0.
- Retire accounting:
  - Stimulus: 3 tokens cc_id=2 dispatched, then retire_valid=4'b0011 both with cc_id=2.
  - Response: cnt=1 and cc_idle[2]=0; next cycle single retire -> cc_idle[2]=1, error=0.
- Simultaneous push+retire:
  - Stimulus: cnt[3]=1, push cc_id=3 and retire cc_id=3 in the same cycle.
  - Response: cc_idle[3] stays 0, cnt=1. A further retire with cnt=0 sets error=1.
- Dedup (macro defined): push (250,0) twice while the first is still stored -> fifo_count=1, dedup_drop pulses once, cnt[0]=1.
